// File: rtl/led_fader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_fader : per-channel PWM brightness stage with stepped afterglow fade  |
// | Option    : LED_FADER_GAMMA_EN squares the shadow duty for the compare    |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module led_fader #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int PWM_PRESCALE = 46,
    parameter int DECAY        = 24
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                STEP,
    input  logic [CHANNELS-1:0] PATTERN,
    output logic [CHANNELS-1:0] LED,
    output logic                FRAME
);

    localparam int                 C_PRE_W   = (PWM_PRESCALE > 0) ? $clog2(PWM_PRESCALE + 1) : 1;
    localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(PWM_PRESCALE);
    localparam logic [WIDTH-1:0]   C_FULL    = '1;
    // One extra bit so the subtraction borrow flags underflow; oversized DECAY clamps to a full drain.
    localparam logic [WIDTH:0]     C_DECAY   = (DECAY >= (1 << WIDTH)) ? {1'b1, {WIDTH{1'b0}}}
                                                                       : (WIDTH + 1)'(DECAY);

    logic [C_PRE_W-1:0] pre_q;
    logic [C_PRE_W-1:0] pre_d;
    logic [WIDTH-1:0]   pwm_cnt_q;
    logic [WIDTH-1:0]   pwm_cnt_d;
    logic               frame_q;
    logic               w_terminal;
    logic               w_boundary;

    always_comb begin
        w_terminal = (pre_q == C_PRE_MAX);
        w_boundary = w_terminal && (pwm_cnt_q == C_FULL);
        pre_d      = w_terminal ? '0 : pre_q + 1'b1;
        pwm_cnt_d  = w_terminal ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            frame_q   <= w_boundary;
        end
    end

    assign FRAME = frame_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] lvl_q;
        logic [WIDTH-1:0] lvl_d;
        logic [WIDTH-1:0] duty_q;
        logic [WIDTH-1:0] w_cmp;
        logic [WIDTH:0]   w_diff;
        logic             led_q;

        // A lit pattern bit wins over a simultaneous fade strobe.
        always_comb begin
            w_diff = {1'b0, lvl_q} - C_DECAY;
            if (PATTERN[i]) begin
                lvl_d = C_FULL;
            end else if (STEP) begin
                lvl_d = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
            end else begin
                lvl_d = lvl_q;
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                lvl_q  <= '0;
                duty_q <= '0;
                led_q  <= 1'b0;
            end else begin
                lvl_q <= lvl_d;
                if (w_boundary) begin
                    duty_q <= lvl_q;
                end
                led_q <= (pwm_cnt_q < w_cmp) || (duty_q == C_FULL);
            end
        end

`ifdef LED_FADER_GAMMA_EN
        logic [WIDTH-1:0] cmp_q;

        // Squared at shadow-load time so the compare path stays a single register deep.
        always_ff @(posedge CLK) begin
            if (RST) begin
                cmp_q <= '0;
            end else if (w_boundary) begin
                cmp_q <= WIDTH'(((2 * WIDTH)'(lvl_q) * (2 * WIDTH)'(lvl_q)) >> WIDTH);
            end
        end

        assign w_cmp = cmp_q;
`else
        assign w_cmp = duty_q;
`endif

        assign LED[i] = led_q;
    end

endmodule
`default_nettype wire
